ext_issue_ctrl: RTL and testbench

- Issue/sequencing controller directly upstream of the extended ALU (MUL/UMUL/ADDF/SUBF/MULF/ITF/FTI) in the EX stage.
- Accepts an extended-op request from ID/EX and holds the operands and func stable on the extended ALU inputs.
- Stalls the pipeline for the function-dependent latency, then captures the result and flags and presents them to EX/DM with a one-cycle valid.

---
 rtl/ext_issue_ctrl_pkg.sv | 29 ++
 rtl/ext_issue_ctrl_if.sv | 42 ++++
 rtl/ext_issue_ctrl_lat_lut.sv | 34 +++
 rtl/ext_issue_ctrl.sv | 118 +++++++++++
 tb/tb_ext_issue_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ext_issue_ctrl_pkg.sv
// Shared definitions for the extended-ALU issue controller: function codes,
// FSM state encoding and default per-function latencies.
package ext_issue_ctrl_pkg;

  localparam logic [2:0] FUNC_MUL  = 3'b000;
  localparam logic [2:0] FUNC_UMUL = 3'b001;
  localparam logic [2:0] FUNC_ADDF = 3'b010;
  localparam logic [2:0] FUNC_SUBF = 3'b011;
  localparam logic [2:0] FUNC_MULF = 3'b100;
  localparam logic [2:0] FUNC_ITF  = 3'b101;
  localparam logic [2:0] FUNC_FTI  = 3'b110;
  localparam logic [2:0] FUNC_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LAT_MUL_DEF  = 2;
  localparam int LAT_UMUL_DEF = 2;
  localparam int LAT_ADDF_DEF = 3;
  localparam int LAT_SUBF_DEF = 3;
  localparam int LAT_MULF_DEF = 3;
  localparam int LAT_ITF_DEF  = 2;
  localparam int LAT_FTI_DEF  = 2;
  localparam int CNT_W_DEF    = 3;

endpackage

// File: rtl/ext_issue_ctrl_if.sv
// Bundle of the ID/EX request side, the extended-ALU side and the EX/DM
// writeback side of the issue controller. The controller is the slave.
interface ext_issue_if;
  import ext_issue_ctrl_pkg::*;

  logic        ext_req;
  logic [2:0]  func;
  logic [31:0] src1;
  logic [31:0] src0;
  logic [4:0]  dst_reg;
  logic        flush;
  logic [31:0] alu_src1;
  logic [31:0] alu_src0;
  logic [2:0]  alu_func;
  logic [31:0] alu_result;
  logic        alu_ov;
  logic        alu_zr;
  logic        alu_neg;
  logic        stall_ext;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_ov;
  logic        wb_zr;
  logic        wb_neg;
  logic        ill_op;

  modport slave (
    input  ext_req, func, src1, src0, dst_reg, flush,
    input  alu_result, alu_ov, alu_zr, alu_neg,
    output alu_src1, alu_src0, alu_func,
    output stall_ext, wb_valid, wb_data, wb_reg, wb_ov, wb_zr, wb_neg, ill_op
  );

  modport master (
    output ext_req, func, src1, src0, dst_reg, flush,
    output alu_result, alu_ov, alu_zr, alu_neg,
    input  alu_src1, alu_src0, alu_func,
    input  stall_ext, wb_valid, wb_data, wb_reg, wb_ov, wb_zr, wb_neg, ill_op
  );

endinterface

// File: rtl/ext_issue_ctrl_lat_lut.sv
// Maps an extended function code to (latency - 1), the value loaded into
// the BUSY countdown. The illegal code maps to 0; it is never accepted.
module ext_lat_lut
  import ext_issue_ctrl_pkg::*;
#(
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_UMUL = LAT_UMUL_DEF,
  parameter int LAT_ADDF = LAT_ADDF_DEF,
  parameter int LAT_SUBF = LAT_SUBF_DEF,
  parameter int LAT_MULF = LAT_MULF_DEF,
  parameter int LAT_ITF  = LAT_ITF_DEF,
  parameter int LAT_FTI  = LAT_FTI_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic [2:0]       i_func,
  output logic [CNT_W-1:0] o_lat_m1
);

  // Pure lookup; every LAT_* fits CNT_W bits once one is subtracted.
  always_comb begin
    o_lat_m1 = '0;
    case (i_func)
      FUNC_MUL:  o_lat_m1 = CNT_W'(LAT_MUL  - 1);
      FUNC_UMUL: o_lat_m1 = CNT_W'(LAT_UMUL - 1);
      FUNC_ADDF: o_lat_m1 = CNT_W'(LAT_ADDF - 1);
      FUNC_SUBF: o_lat_m1 = CNT_W'(LAT_SUBF - 1);
      FUNC_MULF: o_lat_m1 = CNT_W'(LAT_MULF - 1);
      FUNC_ITF:  o_lat_m1 = CNT_W'(LAT_ITF  - 1);
      FUNC_FTI:  o_lat_m1 = CNT_W'(LAT_FTI  - 1);
      default:   o_lat_m1 = '0;
    endcase
  end

endmodule

// File: rtl/ext_issue_ctrl.sv
// Issue/sequencing controller in front of the multi-cycle extended ALU.
// Launches operands, stalls upstream for the function latency, captures
// the result and flags, and presents them with a one-cycle wb_valid.
module ext_issue_ctrl
  import ext_issue_ctrl_pkg::*;
#(
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_UMUL = LAT_UMUL_DEF,
  parameter int LAT_ADDF = LAT_ADDF_DEF,
  parameter int LAT_SUBF = LAT_SUBF_DEF,
  parameter int LAT_MULF = LAT_MULF_DEF,
  parameter int LAT_ITF  = LAT_ITF_DEF,
  parameter int LAT_FTI  = LAT_FTI_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  ext_issue_if.slave   bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_alu_src1;
  logic [31:0]        r_alu_src0;
  logic [2:0]         r_alu_func;
  logic [4:0]         r_dst_shadow;
  logic [31:0]        r_wb_data;
  logic [4:0]         r_wb_reg;
  logic               r_wb_ov;
  logic               r_wb_zr;
  logic               r_wb_neg;
  logic               r_ill_op;

  logic               w_can_issue;
  logic               w_accept;
  logic               w_illegal;
  logic [CNT_W-1:0]   w_lat_m1;

  ext_lat_lut #(
    .LAT_MUL  (LAT_MUL),
    .LAT_UMUL (LAT_UMUL),
    .LAT_ADDF (LAT_ADDF),
    .LAT_SUBF (LAT_SUBF),
    .LAT_MULF (LAT_MULF),
    .LAT_ITF  (LAT_ITF),
    .LAT_FTI  (LAT_FTI),
    .CNT_W    (CNT_W)
  ) u_lat_lut (
    .i_func   (bus.func),
    .o_lat_m1 (w_lat_m1)
  );

  // A new op may start from IDLE or from DONE (back-to-back); flush wins.
  assign w_can_issue = bus.ext_req & ~bus.flush & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_accept    = w_can_issue & (bus.func != FUNC_ILL);
  assign w_illegal   = w_can_issue & (bus.func == FUNC_ILL);

  assign bus.stall_ext = w_accept | (r_state == ST_BUSY);
  assign bus.wb_valid  = (r_state == ST_DONE) & ~bus.flush;
  assign bus.alu_src1  = r_alu_src1;
  assign bus.alu_src0  = r_alu_src0;
  assign bus.alu_func  = r_alu_func;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_reg    = r_wb_reg;
  assign bus.wb_ov     = r_wb_ov;
  assign bus.wb_zr     = r_wb_zr;
  assign bus.wb_neg    = r_wb_neg;
  assign bus.ill_op    = r_ill_op;

  // FSM, latency countdown, operand launch and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_alu_src1   <= '0;
      r_alu_src0   <= '0;
      r_alu_func   <= '0;
      r_dst_shadow <= '0;
      r_wb_data    <= '0;
      r_wb_reg     <= '0;
      r_wb_ov      <= 1'b0;
      r_wb_zr      <= 1'b0;
      r_wb_neg     <= 1'b0;
      r_ill_op     <= 1'b0;
    end else begin
      r_ill_op <= w_illegal;
      if (bus.flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_alu_src1   <= bus.src1;
        r_alu_src0   <= bus.src0;
        r_alu_func   <= bus.func;
        r_dst_shadow <= bus.dst_reg;
        r_cnt        <= w_lat_m1;
        r_state      <= ST_BUSY;
      end else begin
        case (r_state)
          ST_BUSY: begin
            if (r_cnt == '0) begin
              r_wb_data <= bus.alu_result;
              r_wb_reg  <= r_dst_shadow;
              r_wb_ov   <= bus.alu_ov;
              r_wb_zr   <= bus.alu_zr;
              r_wb_neg  <= bus.alu_neg;
              r_state   <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_issue_ctrl.sv
// Directed bench for ext_issue_ctrl. Each task drives one scenario cycle by
// cycle and compares outputs against hand-computed values. The ALU result
// is presented only in the cycle it must be captured; junk otherwise.
module tb_ext_issue_ctrl;
  import ext_issue_ctrl_pkg::*;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ext_issue_if bus();

  ext_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ext_req = 1'b0; bus.func = 3'b000; bus.src1 = '0; bus.src0 = '0;
    bus.dst_reg = '0; bus.flush = 1'b0; bus.alu_result = JUNK;
    bus.alu_ov = 1'b0; bus.alu_zr = 1'b0; bus.alu_neg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if (bus.stall_ext !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_ext); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
    checks++; if (bus.alu_src1 !== 32'h0 || bus.alu_src0 !== 32'h0 || bus.alu_func !== 3'b000) begin errors++; $display("FAIL reset_alu: got %h %h %b want 0", bus.alu_src1, bus.alu_src0, bus.alu_func); end
    checks++; if (bus.wb_data !== 32'h0 || bus.wb_reg !== 5'd0 || bus.ill_op !== 1'b0) begin errors++; $display("FAIL reset_wb: got %h %0d ill=%b want 0", bus.wb_data, bus.wb_reg, bus.ill_op); end
  endtask

  task automatic test_mul();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_MUL; bus.src1 = 32'hFFFF_FFFE; bus.src0 = 32'd3; bus.dst_reg = 5'd7; #1;
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL mul_stall_T: got %b want 1", bus.stall_ext); end
    tick();
    bus.ext_req = 1'b0; bus.src1 = 32'h1111_1111; bus.src0 = 32'h2222_2222; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_T1: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    checks++; if (bus.alu_src1 !== 32'hFFFF_FFFE || bus.alu_src0 !== 32'd3 || bus.alu_func !== FUNC_MUL) begin errors++; $display("FAIL mul_launch: got %h %h %b want fffffffe 00000003 000", bus.alu_src1, bus.alu_src0, bus.alu_func); end
    tick();
    bus.alu_result = 32'hFFFF_FFFA; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_T2: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick();
    bus.alu_result = JUNK; #1;
    checks++; if (bus.stall_ext !== 1'b0 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL mul_T3: got stall=%b valid=%b want 0 1", bus.stall_ext, bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'hFFFF_FFFA || bus.wb_reg !== 5'd7) begin errors++; $display("FAIL mul_result: got %h r%0d want fffffffa r7", bus.wb_data, bus.wb_reg); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.stall_ext !== 1'b0 || bus.wb_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_T4: got valid=%b stall=%b data=%h want 0 0 fffffffa", bus.wb_valid, bus.stall_ext, bus.wb_data); end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_ADDF; bus.src1 = 32'h3F80_0000; bus.src0 = 32'h4000_0000; bus.dst_reg = 5'd3; #1;
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL b2b_stall_T: got %b want 1", bus.stall_ext); end
    tick(); bus.ext_req = 1'b0; #1;
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL b2b_stall_T1: got %b want 1", bus.stall_ext); end
    tick(); #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_T2: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick(); bus.alu_result = 32'h4040_0000; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_T3: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick();
    bus.alu_result = JUNK; bus.ext_req = 1'b1; bus.func = FUNC_ITF; bus.src1 = 32'd5; bus.src0 = 32'd0; bus.dst_reg = 5'd9; #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h4040_0000 || bus.wb_reg !== 5'd3) begin errors++; $display("FAIL b2b_addf_result: got valid=%b %h r%0d want 1 40400000 r3", bus.wb_valid, bus.wb_data, bus.wb_reg); end
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL b2b_stall_T4: got %b want 1", bus.stall_ext); end
    tick(); bus.ext_req = 1'b0; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_T5: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    checks++; if (bus.alu_src1 !== 32'd5 || bus.alu_func !== FUNC_ITF) begin errors++; $display("FAIL b2b_itf_launch: got %h %b want 00000005 101", bus.alu_src1, bus.alu_func); end
    tick(); bus.alu_result = 32'h40A0_0000; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_T6: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick(); bus.alu_result = JUNK; #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h40A0_0000 || bus.wb_reg !== 5'd9 || bus.stall_ext !== 1'b0) begin errors++; $display("FAIL b2b_itf_result: got valid=%b %h r%0d stall=%b want 1 40a00000 r9 0", bus.wb_valid, bus.wb_data, bus.wb_reg, bus.stall_ext); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_T8_valid: got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_illegal();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_ILL; bus.src1 = 32'h1234_5678; bus.src0 = 32'h9ABC_DEF0; bus.dst_reg = 5'd1; #1;
    checks++; if (bus.stall_ext !== 1'b0 || bus.ill_op !== 1'b0) begin errors++; $display("FAIL ill_T: got stall=%b ill=%b want 0 0", bus.stall_ext, bus.ill_op); end
    tick(); bus.ext_req = 1'b0; #1;
    checks++; if (bus.ill_op !== 1'b1 || bus.stall_ext !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ill_T1: got ill=%b stall=%b valid=%b want 1 0 0", bus.ill_op, bus.stall_ext, bus.wb_valid); end
    checks++; if (bus.alu_src1 !== 32'd5 || bus.alu_src0 !== 32'd0 || bus.alu_func !== FUNC_ITF) begin errors++; $display("FAIL ill_alu_hold: got %h %h %b want 00000005 00000000 101", bus.alu_src1, bus.alu_src0, bus.alu_func); end
    tick();
    checks++; if (bus.ill_op !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ill_T2: got ill=%b valid=%b want 0 0", bus.ill_op, bus.wb_valid); end
  endtask

  task automatic test_flush();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_MULF; bus.src1 = 32'h4000_0000; bus.src0 = 32'h4040_0000; bus.dst_reg = 5'd4; #1;
    tick(); bus.ext_req = 1'b0; #1;
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL flush_T1_stall: got %b want 1", bus.stall_ext); end
    tick(); bus.flush = 1'b1; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_T2: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick(); bus.flush = 1'b0; bus.alu_result = 32'h40C0_0000; #1;
    checks++; if (bus.stall_ext !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_T3: got stall=%b valid=%b want 0 0", bus.stall_ext, bus.wb_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b0 || bus.stall_ext !== 1'b0) begin errors++; $display("FAIL flush_after%0d: got valid=%b stall=%b want 0 0", i, bus.wb_valid, bus.stall_ext); end
    end
    bus.alu_result = JUNK;
    // Flush landing in the DONE cycle, together with a new request.
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_UMUL; bus.src1 = 32'd2; bus.src0 = 32'd2; bus.dst_reg = 5'd5; #1;
    tick(); bus.ext_req = 1'b0; #1;
    tick(); bus.alu_result = 32'd4; #1;
    tick(); bus.alu_result = JUNK; bus.flush = 1'b1; bus.ext_req = 1'b1; bus.func = FUNC_MUL; #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.stall_ext !== 1'b0) begin errors++; $display("FAIL flush_done: got valid=%b stall=%b want 0 0", bus.wb_valid, bus.stall_ext); end
    tick(); bus.flush = 1'b0; bus.ext_req = 1'b0; #1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.stall_ext !== 1'b0 || bus.wb_data !== 32'd4) begin errors++; $display("FAIL flush_done_next: got valid=%b stall=%b data=%h want 0 0 00000004", bus.wb_valid, bus.stall_ext, bus.wb_data); end
  endtask

  task automatic test_reset_mid_busy();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_FTI; bus.src1 = 32'h40E0_0000; bus.dst_reg = 5'd12; #1;
    tick(); bus.ext_req = 1'b0; rst = 1'b1; #1;
    tick(); rst = 1'b0; bus.alu_result = 32'd7; #1;
    checks++; if (bus.stall_ext !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got stall=%b valid=%b want 0 0", bus.stall_ext, bus.wb_valid); end
    checks++; if (bus.alu_src1 !== 32'h0 || bus.alu_func !== 3'b000 || bus.wb_data !== 32'h0 || bus.wb_reg !== 5'd0) begin errors++; $display("FAIL rst_mid_regs: got %h %b %h r%0d want 0", bus.alu_src1, bus.alu_func, bus.wb_data, bus.wb_reg); end
    tick(); bus.alu_result = JUNK; #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_novalid: got %b want 0", bus.wb_valid); end
    bus.ext_req = 1'b1; bus.func = FUNC_UMUL; bus.src1 = 32'd6; bus.src0 = 32'd7; bus.dst_reg = 5'd2; #1;
    checks++; if (bus.stall_ext !== 1'b1) begin errors++; $display("FAIL umul_stall_T: got %b want 1", bus.stall_ext); end
    tick(); bus.ext_req = 1'b0; #1;
    tick(); bus.alu_result = 32'd42; #1;
    checks++; if (bus.stall_ext !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL umul_T2: got stall=%b valid=%b want 1 0", bus.stall_ext, bus.wb_valid); end
    tick(); bus.alu_result = JUNK; #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd42 || bus.wb_reg !== 5'd2 || bus.stall_ext !== 1'b0) begin errors++; $display("FAIL umul_result: got valid=%b %h r%0d stall=%b want 1 0000002a r2 0", bus.wb_valid, bus.wb_data, bus.wb_reg, bus.stall_ext); end
  endtask

  task automatic test_flags();
    tick();
    bus.ext_req = 1'b1; bus.func = FUNC_SUBF; bus.src1 = 32'h3F80_0000; bus.src0 = 32'h3F80_0000; bus.dst_reg = 5'd30;
    bus.alu_ov = 1'b1; bus.alu_zr = 1'b0; bus.alu_neg = 1'b1; #1;
    tick(); bus.ext_req = 1'b0; #1;
    tick(); #1;
    tick(); bus.alu_result = 32'h0; bus.alu_ov = 1'b0; bus.alu_zr = 1'b1; bus.alu_neg = 1'b0; #1;
    tick(); bus.alu_result = JUNK; bus.alu_ov = 1'b1; bus.alu_zr = 1'b0; bus.alu_neg = 1'b1; #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0 || bus.wb_reg !== 5'd30) begin errors++; $display("FAIL subf_result: got valid=%b %h r%0d want 1 00000000 r30", bus.wb_valid, bus.wb_data, bus.wb_reg); end
    checks++; if (bus.wb_zr !== 1'b1 || bus.wb_neg !== 1'b0 || bus.wb_ov !== 1'b0) begin errors++; $display("FAIL subf_flags: got zr=%b neg=%b ov=%b want 1 0 0", bus.wb_zr, bus.wb_neg, bus.wb_ov); end
    tick();
    checks++; if (bus.wb_zr !== 1'b1 || bus.wb_neg !== 1'b0 || bus.wb_ov !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL subf_flags_hold: got zr=%b neg=%b ov=%b valid=%b want 1 0 0 0", bus.wb_zr, bus.wb_neg, bus.wb_ov, bus.wb_valid); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_busy();
    test_flags();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
